// File: rtl/seg_pkg.sv
// Shared constants, FSM encoding and digit helpers for the multiplexed 4-digit BCD display path.
// Pure declarations: no latency, no flow control.
package seg_pkg;

   localparam int NUM_DIGITS  = 4;
   localparam int DIGIT_W     = 4;
   localparam int BIN_W       = 14;
   localparam int BCD_W       = NUM_DIGITS * DIGIT_W;
   localparam int MAX_VAL     = 9999;
   localparam int CONV_CYCLES = 14;
   localparam int STEP_W      = $clog2(CONV_CYCLES);
   localparam int IDX_W       = $clog2(NUM_DIGITS);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CONV   = 2'd1,
      ST_COMMIT = 2'd2
   } state_e;

   typedef logic [BCD_W-1:0] bcd_t;

   // Double-dabble correction applied before every shift: any digit >=5 gets +3.
   function automatic bcd_t dabble_adjust(input bcd_t bcd);
      bcd_t r;
      r = bcd;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (bcd[k*DIGIT_W +: DIGIT_W] >= 4'd5)
            r[k*DIGIT_W +: DIGIT_W] = bcd[k*DIGIT_W +: DIGIT_W] + 4'd3;
      end
      return r;
   endfunction

   function automatic logic slot_blanked(input bcd_t bcd, input logic [IDX_W-1:0] idx);
      logic blank;
      blank = (idx != '0);
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (k >= int'(idx) && bcd[k*DIGIT_W +: DIGIT_W] != '0)
            blank = 1'b0;
      end
      return blank;
   endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble converter, one shift per cycle, CONV_CYCLES cycles after start.
// Latency: result valid the cycle after done; start is ignored while busy.
module bin_to_bcd_seq
   import seg_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [BIN_W-1:0] bin,
   output logic             busy,
   output logic             done,
   output logic [BCD_W-1:0] bcd
);

   logic [BIN_W-1:0]  shreg;
   logic [STEP_W-1:0] step;
   bcd_t              adj;

   assign adj  = dabble_adjust(bcd);
   // done marks the cycle whose closing edge performs the final shift.
   assign done = busy && (step == STEP_W'(CONV_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         busy  <= 1'b0;
         step  <= '0;
         shreg <= '0;
         bcd   <= '0;
      end else if (start && !busy) begin
         busy  <= 1'b1;
         step  <= '0;
         shreg <= bin;
         bcd   <= '0;
      end else if (busy) begin
         {bcd, shreg} <= {adj[BCD_W-2:0], shreg, 1'b0};
         step         <= step + 1'b1;
         if (done)
            busy <= 1'b0;
      end
   end

endmodule

// File: rtl/seg_digit_scanner.sv
// Binary value -> clamped BCD display register -> time-multiplexed digit/anode drive; commit 15 cycles after accept.
// in_ready is high only while idle; the display keeps the old digits until the new conversion commits.
module seg_digit_scanner
   import seg_pkg::*;
#(
   parameter int SCAN_DIV = 1000,
   parameter bit LZB      = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [BIN_W-1:0]      in_value,
   output logic                  in_ready,
   output logic                  ovf,
   output logic [DIGIT_W-1:0]    bcd_out,
   output logic [NUM_DIGITS-1:0] an_n
);

   localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   state_e             state, state_nxt;
   logic               xfer;
   logic               conv_start, conv_busy, conv_done;
   logic [BIN_W-1:0]   conv_in;
   bcd_t               conv_bcd;
   bcd_t               disp;
   logic               ovf_pend;
   logic [PRE_W-1:0]   presc;
   logic [IDX_W-1:0]   idx;

   assign in_ready = (state == ST_IDLE) && !conv_busy;
   assign xfer     = in_valid && in_ready;
   assign conv_in  = (in_value > BIN_W'(MAX_VAL)) ? BIN_W'(MAX_VAL) : in_value;

   bin_to_bcd_seq u_conv (
      .clk   (clk),
      .rst   (rst),
      .start (conv_start),
      .bin   (conv_in),
      .busy  (conv_busy),
      .done  (conv_done),
      .bcd   (conv_bcd)
   );

   always_comb begin
      state_nxt  = state;
      conv_start = 1'b0;
      case (state)
         ST_IDLE: begin
            if (xfer) begin
               state_nxt  = ST_CONV;
               conv_start = 1'b1;
            end
         end
         ST_CONV:   if (conv_done) state_nxt = ST_COMMIT;
         ST_COMMIT: state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         ovf_pend <= 1'b0;
         ovf      <= 1'b0;
         disp     <= '0;
      end else begin
         state <= state_nxt;
         if (xfer)
            ovf_pend <= (in_value > BIN_W'(MAX_VAL));
         if (state == ST_COMMIT) begin
            disp <= conv_bcd;
            ovf  <= ovf_pend;
         end
      end
   end

   // Scan runs free of the FSM so the refresh rate never stalls during conversion.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc   <= '0;
         idx     <= '0;
         bcd_out <= '0;
         an_n    <= '1;
      end else begin
         if (presc == PRE_W'(SCAN_DIV - 1)) begin
            presc <= '0;
            idx   <= idx + 1'b1;
         end else begin
            presc <= presc + 1'b1;
         end
         bcd_out <= disp[int'(idx)*DIGIT_W +: DIGIT_W];
         if (LZB && slot_blanked(disp, idx))
            an_n <= '1;
         else
            an_n <= ~(NUM_DIGITS'(1) << idx);
      end
   end

endmodule
